// File: rtl/ram_be_seq.sv
// ram_be_seq: clocked big-endian byte-addressable data memory with request/done handshake,
// byte/half/word/two-beat dword access. Optional misalignment fault: define RAM_ALIGN_CHECK_EN.
module ram_be_seq #(
   parameter  int ADDR_W = 8,
   localparam int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              req_i,
   input  logic              r_w_i,
   input  logic [1:0]        dtype_i,
   input  logic              signed_rd_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_in_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              beat_o,
   output logic              need_wd_o,
   output logic              err_o,
   output logic [DATA_W-1:0] data_out_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DW2    = 2'd2
   } state_e;

   state_e              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [1:0]          dtype_q;
   logic                r_w_q;
   logic                signed_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                busy_q;
   logic                done_q;
   logic                beat_q;
   logic                need_wd_q;
   logic                err_q;
   logic [DATA_W-1:0]   data_out_q;
   logic [7:0]          mem_q [2**ADDR_W];

   logic [ADDR_W-1:0]   low_mask_s;
   logic [ADDR_W-1:0]   req_addr_s;
   logic                fault_s;
   logic                in_dw2_s;
   logic                wr_en_s;
   logic [4:0]          shift_s;
   logic [2:0]          size_cnt_s;
   logic [2:0]          wr_cnt_s;
   logic [ADDR_W-1:0]   base_s;
   logic [ADDR_W-1:0]   byte_addr_s [4];
   logic [DATA_W-1:0]   wr_lj_s;
   logic [DATA_W-1:0]   unit_s;
   logic [DATA_W-1:0]   unit_rj_s;
   logic [DATA_W-1:0]   rd_fmt_s;

`ifdef RAM_ALIGN_CHECK_EN
   logic                mis_q;
   logic                req_mis_s;

   assign req_mis_s = |(addr_i & low_mask_s);
   assign fault_s   = mis_q;
`else
   assign fault_s   = 1'b0;
`endif

   always_comb begin
      case (dtype_i)
         2'b00:   low_mask_s = ADDR_W'(3'd0);
         2'b01:   low_mask_s = ADDR_W'(3'd1);
         2'b10:   low_mask_s = ADDR_W'(3'd3);
         default: low_mask_s = ADDR_W'(3'd7);
      endcase
      req_addr_s = addr_i & ~low_mask_s;
   end

   // Narrow units are handled left-justified in a 32-bit lane; shift_s realigns them.
   always_comb begin
      case (dtype_q)
         2'b00: begin
            shift_s    = 5'd24;
            size_cnt_s = 3'd1;
         end
         2'b01: begin
            shift_s    = 5'd16;
            size_cnt_s = 3'd2;
         end
         default: begin
            shift_s    = 5'd0;
            size_cnt_s = 3'd4;
         end
      endcase
   end

   always_comb begin
      in_dw2_s = (state_q == S_DW2);
      if (in_dw2_s) begin
         base_s   = addr_q + ADDR_W'(3'd4);
         wr_lj_s  = data_in_i;
         wr_cnt_s = 3'd4;
      end else begin
         base_s   = addr_q;
         wr_lj_s  = wdata_q << shift_s;
         wr_cnt_s = size_cnt_s;
      end
      wr_en_s = !reset_i && r_w_q && (in_dw2_s || ((state_q == S_ACCESS) && !fault_s));
      unit_s  = 32'd0;
      // Read path sees the bytes being written this edge, giving read-after-write data.
      for (int i = 0; i < 4; i++) begin
         byte_addr_s[i] = base_s + ADDR_W'(i);
         if (wr_en_s && (3'(i) < wr_cnt_s)) begin
            unit_s[8*(3-i) +: 8] = wr_lj_s[8*(3-i) +: 8];
         end else begin
            unit_s[8*(3-i) +: 8] = mem_q[byte_addr_s[i]];
         end
      end
      unit_rj_s = unit_s >> shift_s;
      case (dtype_q)
         2'b00:   rd_fmt_s = {{24{signed_q & unit_rj_s[7]}}, unit_rj_s[7:0]};
         2'b01:   rd_fmt_s = {{16{signed_q & unit_rj_s[15]}}, unit_rj_s[15:0]};
         default: rd_fmt_s = unit_rj_s;
      endcase
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_en_s && (3'(i) < wr_cnt_s)) begin
            mem_q[byte_addr_s[i]] <= wr_lj_s[8*(3-i) +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         dtype_q    <= 2'b00;
         r_w_q      <= 1'b0;
         signed_q   <= 1'b0;
         wdata_q    <= 32'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         beat_q     <= 1'b0;
         need_wd_q  <= 1'b0;
         err_q      <= 1'b0;
         data_out_q <= 32'd0;
`ifdef RAM_ALIGN_CHECK_EN
         mis_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q    <= 1'b0;
               need_wd_q <= 1'b0;
               if (req_i) begin
                  state_q  <= S_ACCESS;
                  busy_q   <= 1'b1;
                  addr_q   <= req_addr_s;
                  dtype_q  <= dtype_i;
                  r_w_q    <= r_w_i;
                  signed_q <= signed_rd_i;
                  wdata_q  <= data_in_i;
`ifdef RAM_ALIGN_CHECK_EN
                  mis_q    <= req_mis_s;
`endif
               end else begin
                  busy_q   <= 1'b0;
               end
            end
            S_ACCESS: begin
               done_q <= 1'b1;
               beat_q <= 1'b0;
               err_q  <= fault_s;
               if (!fault_s) begin
                  data_out_q <= rd_fmt_s;
               end
               if ((dtype_q == 2'b11) && !fault_s) begin
                  state_q   <= S_DW2;
                  need_wd_q <= 1'b1;
               end else begin
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
               end
            end
            S_DW2: begin
               state_q    <= S_IDLE;
               busy_q     <= 1'b0;
               done_q     <= 1'b1;
               beat_q     <= 1'b1;
               err_q      <= 1'b0;
               need_wd_q  <= 1'b0;
               data_out_q <= rd_fmt_s;
            end
            default: begin
               state_q   <= S_IDLE;
               busy_q    <= 1'b0;
               done_q    <= 1'b0;
               need_wd_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign beat_o     = beat_q;
   assign need_wd_o  = need_wd_q;
   assign err_o      = err_q;
   assign data_out_o = data_out_q;

endmodule
